cmp_iter: RTL and testbench
===========================

// Module: cmp_iter
// PURPOSE
//   Parametrised multi-cycle branch/compare unit for the CPU datapath. Compares two
//   WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with optional early exit
//   on the first differing chunk. Valid/ready handshake on both sides so the core can
//   stall on it. Supports EQ/NE/LT/GE/LTU/GEU.
// PARAMETERS
//   WIDTH      32  operand width; WIDTH % CHUNK == 0 required
//   CHUNK      8   bits compared per cycle; N = WIDTH/CHUNK chunks; CHUNK==WIDTH -> 1 cycle
//   EARLY_EXIT 1   1: finish on first differing chunk; 0: always scan all N chunks
// PORTS
//   i_clk    in   1      clock, all state on rising edge
//   i_rst    in   1      synchronous reset, active-high
//   i_valid  in   1      request valid
//   o_ready  out  1      unit can accept a request (state IDLE)
//   i_op     in   3      0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2,3 illegal
//   i_a      in   WIDTH  operand A
//   i_b      in   WIDTH  operand B
//   o_valid  out  1      result valid
//   i_ready  in   1      consumer accepts result
//   o_res    out  1      comparison result, meaningful only while o_valid
// BEHAVIOUR
//   Reset: state IDLE, o_valid=0, o_res=0, internal flags cleared; o_ready=1 from the
//     first cycle after reset deasserts. Reset mid-RUN or mid-DONE aborts the op; no
//     o_valid is produced for it.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: o_ready=1. On i_valid&&o_ready latch i_op, i_a, i_b; idx=N-1; diff=0; -> RUN.
//   RUN (o_ready=0, o_valid=0): each cycle compare chunk idx of A and B unsigned. For
//     LT/GE the top chunk (idx N-1) is compared with its MSB inverted in both operands
//     (signed order). First chunk that differs records lt=(a_chunk<b_chunk), diff=1;
//     later chunks never overwrite it.
//     EARLY_EXIT=1: -> DONE at the edge processing the first differing chunk or chunk 0.
//     EARLY_EXIT=0: -> DONE only at the edge processing chunk 0.
//   Result formed on the DONE-entry edge into o_res: EQ=!diff, NE=diff, LT/LTU=diff&&lt,
//     GE/GEU=!(diff&&lt); illegal ops -> o_res=0, still complete normally.
//   Latency: accept at edge E0; o_valid=1 after edge Ek, k = 1-based position (from MSB)
//     of first differing chunk, or N if equal / EARLY_EXIT=0. Max latency N+1 edges incl.
//     accept; next accept no earlier than the edge after the result handshake.
//   DONE: o_valid=1, o_res registered and stable until i_ready. On o_valid&&i_ready
//     -> IDLE, o_valid=0 next cycle. i_valid while not IDLE is ignored (o_ready=0);
//     operands are latched, so input changes after accept have no effect.
//   No combinational path from i_valid/i_a/i_b to any output; o_ready and o_valid
//     decode from state only.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//   EQ a=b=0x12345678 -> o_valid after 4 RUN edges, o_res=1; NE same -> 0.
//   LTU a=0x01000000 b=0x00FFFFFF, EARLY_EXIT=1 -> o_valid after 1 RUN edge, o_res=0;
//     EARLY_EXIT=0 -> after 4 RUN edges, o_res=0.
//   LT a=0x80000000 b=0x00000001 -> 1; LTU same -> 0; GE a=0xFFFFFFFF b=0xFFFFFFFE -> 1.
//   Backpressure: hold i_ready=0 5 cycles in DONE -> o_valid/o_res stable, o_ready=0,
//     pulsed i_valid ignored; release -> one handshake, IDLE next cycle.
//   Assert i_rst 1 cycle during RUN -> no o_valid, o_ready=1 after; next EQ 5,5 -> 1.
//   Op 3'b010 -> completes, o_res=0; CHUNK=32 build: every op done after 1 RUN edge.

Source files
------------

// File: rtl/cmp_iter_if.sv
// Request/response bundle for the iterative compare unit.
// The master drives the request and the result-ready; the slave (the unit) drives the rest.
interface cmp_iter_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic             o_res;

    // Both channels transfer only on a cycle where valid and ready are both high at the rising edge.
    modport master (
        output i_valid, i_op, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_res
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_ready,
        output o_ready, o_valid, o_res
    );
endinterface

// File: rtl/cmp_iter.sv
// Multi-cycle compare unit: scans two operands CHUNK bits per cycle, MSB chunk first,
// and returns a single EQ/NE/LT/GE/LTU/GEU result through a valid/ready handshake.
module cmp_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    cmp_iter_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NE  = 3'd1;
    localparam logic [2:0] OP_LT  = 3'd4;
    localparam logic [2:0] OP_GE  = 3'd5;
    localparam logic [2:0] OP_LTU = 3'd6;
    localparam logic [2:0] OP_GEU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             diff;
    logic             lt;
    logic             valid_q;
    logic             res_q;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             chunk_ne;
    logic             chunk_lt;
    logic             diff_n;
    logic             lt_n;
    logic             finish;

    function automatic logic op_result(input logic [2:0] op, input logic d, input logic l);
        case (op)
            OP_EQ:          op_result = !d;
            OP_NE:          op_result = d;
            OP_LT, OP_LTU:  op_result = d && l;
            OP_GE, OP_GEU:  op_result = !(d && l);
            default:        op_result = 1'b0;
        endcase
    endfunction

    // Operands shift left each RUN cycle, so the chunk under test is always the top one.
    // Flipping the sign bit of the top chunk turns the unsigned chunk compare into signed order.
    always_comb begin
        ca = a_q[WIDTH-1 -: CHUNK];
        cb = b_q[WIDTH-1 -: CHUNK];
        if ((op_q == OP_LT || op_q == OP_GE) && idx == LAST) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        chunk_ne = (ca != cb);
        chunk_lt = (ca < cb);
        diff_n   = diff | chunk_ne;
        lt_n     = diff ? lt : chunk_lt;
        finish   = (idx == '0) || (EARLY_EXIT && chunk_ne);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            diff    <= 1'b0;
            lt      <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        op_q  <= bus.i_op;
                        a_q   <= bus.i_a;
                        b_q   <= bus.i_b;
                        idx   <= LAST;
                        diff  <= 1'b0;
                        lt    <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff <= diff_n;
                    lt   <= lt_n;
                    a_q  <= a_q << CHUNK;
                    b_q  <= b_q << CHUNK;
                    idx  <= idx - IW'(1);
                    if (finish) begin
                        res_q   <= op_result(op_q, diff_n, lt_n);
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_res   = res_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_cmp_iter.sv
// Bench for cmp_iter: three builds (early exit, full scan, single chunk) driven with the same
// requests and checked against an arithmetic reference of the compare result and latency.
module tb_cmp_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmp_iter_if #(.WIDTH(32)) bus0 ();
    cmp_iter_if #(.WIDTH(32)) bus1 ();
    cmp_iter_if #(.WIDTH(32)) bus2 ();
    logic [1:0] st0, st1, st2;

    cmp_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0), .dbg_state(st0));
    cmp_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1), .dbg_state(st1));
    cmp_iter #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1'b1)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2), .dbg_state(st2));

    logic [2:0] ov, rs, rd;
    assign ov = {bus2.o_valid, bus1.o_valid, bus0.o_valid};
    assign rs = {bus2.o_res,   bus1.o_res,   bus0.o_res};
    assign rd = {bus2.o_ready, bus1.o_ready, bus0.o_ready};

    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the whole operands.
    function automatic logic ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    ref_res = (a == b);
            3'd1:    ref_res = (a != b);
            3'd4:    ref_res = ($signed(a) <  $signed(b));
            3'd5:    ref_res = ($signed(a) >= $signed(b));
            3'd6:    ref_res = (a <  b);
            3'd7:    ref_res = (a >= b);
            default: ref_res = 1'b0;
        endcase
    endfunction

    // Latency = position (from MSB) of the chunk holding the highest differing bit, else all chunks.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int chunk);
        logic [31:0] x;
        x = a ^ b;
        for (int m = 31; m >= 0; m--)
            if (x[m]) return (31 - m) / chunk + 1;
        return 32 / chunk;
    endfunction

    task automatic drive_req(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus0.i_valid = v; bus0.i_op = op; bus0.i_a = a; bus0.i_b = b;
        bus1.i_valid = v; bus1.i_op = op; bus1.i_a = a; bus1.i_b = b;
        bus2.i_valid = v; bus2.i_op = op; bus2.i_a = a; bus2.i_b = b;
    endtask

    task automatic drive_rdy(input logic r);
        bus0.i_ready = r;
        bus1.i_ready = r;
        bus2.i_ready = r;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic exp_res, input int exp_lat0, input int hold);
        int got[3];
        logic r;
        exp_q.push_back(exp_res);
        @(negedge clk);
        check("ready_idle", {29'd0, rd}, 32'h7);
        drive_req(1'b1, op, a, b);
        @(posedge clk); #1;
        drive_req(1'b0, 3'($urandom), $urandom, $urandom);
        check("run_no_valid", {26'd0, ov, rd}, 32'h0);
        got = '{0, 0, 0};
        for (int c = 1; c <= 12 && (got[0] == 0 || got[1] == 0 || got[2] == 0); c++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++)
                if (ov[j] && got[j] == 0) got[j] = c;
        end
        check("lat_early", got[0], exp_lat0);
        check("lat_full", got[1], 4);
        check("lat_chunk32", got[2], 1);
        r = exp_q.pop_front();
        check("res", {29'd0, rs}, {29'd0, {3{r}}});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive_req(1'b1, 3'd0, 32'd0, 32'd0);
            @(posedge clk); #1;
            check("bp_hold", {23'd0, ov, rs, rd}, {23'd0, 3'b111, {3{r}}, 3'b000});
        end
        @(negedge clk);
        drive_req(1'b0, 3'd0, 32'd0, 32'd0);
        drive_rdy(1'b1);
        @(posedge clk); #1;
        drive_rdy(1'b0);
        check("handshake_idle", {26'd0, ov, rd}, {26'd0, 3'b000, 3'b111});
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        drive_req(1'b0, 3'd0, 32'd0, 32'd0);
        drive_rdy(1'b0);
        vecs.push_back('{3'd0, 32'h12345678, 32'h12345678, 1'b1, 4});
        vecs.push_back('{3'd1, 32'h12345678, 32'h12345678, 1'b0, 4});
        vecs.push_back('{3'd6, 32'h01000000, 32'h00FFFFFF, 1'b0, 1});
        vecs.push_back('{3'd4, 32'h80000000, 32'h00000001, 1'b1, 1});
        vecs.push_back('{3'd6, 32'h80000000, 32'h00000001, 1'b0, 1});
        vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 4});
        vecs.push_back('{3'd2, 32'h00000005, 32'h00000006, 1'b0, 4});
        vecs.push_back('{3'd3, 32'h00AA0000, 32'h00BB0000, 1'b0, 2});
        vecs.push_back('{3'd7, 32'h00001000, 32'h00002000, 1'b0, 3});
        vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1});
        vecs.push_back('{3'd5, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1});
        vecs.push_back('{3'd6, 32'h00000100, 32'h00000200, 1'b1, 3});
        vecs.push_back('{3'd4, 32'h00000005, 32'h00000005, 1'b0, 4});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_state", {23'd0, ov, rs, rd}, {23'd0, 3'b000, 3'b000, 3'b111});

        foreach (vecs[i])
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0);

        // Backpressure: result held five cycles while request pulses are offered.
        run_txn(3'd6, 32'h00000100, 32'h00000200, 1'b1, 3, 5);

        // Reset while the full-scan builds are still in RUN.
        @(negedge clk);
        drive_req(1'b1, 3'd0, 32'h11111111, 32'h11111112);
        @(posedge clk); #1;
        drive_req(1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_state", {26'd0, ov, rd}, {26'd0, 3'b000, 3'b111});
        begin
            logic [2:0] seen;
            seen = 3'b000;
            repeat (6) begin
                @(posedge clk); #1;
                seen = seen | ov;
            end
            check("rst_no_valid", {29'd0, seen}, 32'd0);
        end
        run_txn(3'd0, 32'd5, 32'd5, 1'b1, 4, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a, b;
            logic [2:0] op;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = {a[31:16], 16'($urandom)};
            endcase
            op = 3'($urandom_range(0, 7));
            run_txn(op, a, b, ref_res(op, a, b), ref_lat(a, b, 8), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
